// File: rtl/isa_ctrl_pkg.sv
// isa_ctrl_pkg: op codes, FSM states, transceiver bundle and timing defaults for the ISA bridge
package isa_ctrl_pkg;
  localparam logic [3:0] OP_IDLE = 4'd0, OP_WRITE = 4'd1, OP_READ = 4'd2;
  localparam int SETUP_CYC_DEF = 2, STROBE_CYC_DEF = 6, HOLD_CYC_DEF = 2, TIMEOUT_CYC_DEF = 32;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT_CS, S_STROBE, S_HOLD, S_ABORT, S_DONE} state_t;
  typedef struct packed {logic sd1; logic sd2; logic sa1; logic sa2; logic in; logic out;} xcvr_t;
  function automatic logic bus_active(input state_t s);
    return s inside {S_SETUP, S_WAIT_CS, S_STROBE, S_HOLD, S_ABORT};
  endfunction
endpackage

// File: rtl/isa_xcvr_ctrl.sv
// isa_xcvr_ctrl: 74LVC4245 OE/DIR decode from bus cycle state and operation
module isa_xcvr_ctrl
  import isa_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [3:0]  op,
  output xcvr_t       oe,
  output xcvr_t       dir
);
  logic act, wr;
  assign act = bus_active(state);
  assign wr  = act && op == OP_WRITE;
  // address and control buffers stay enabled; data buffers only open around a cycle
  assign oe  = {!act, !act, 4'b0000};
  assign dir = {wr, wr, 2'b11, 1'b0, 1'b1};
endmodule

// File: rtl/isa_bus_controller.sv
// isa_bus_controller: runs one 16-bit ISA I/O write or read per ap_start, with IOCS16# timeout
module isa_bus_controller
  import isa_ctrl_pkg::*;
#(
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int STROBE_CYC  = STROBE_CYC_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)(
  input  logic        clk_in_16m,
  input  logic        rst_n,
  output logic        oe_isa_sd1,
  output logic        oe_isa_sd2,
  output logic        oe_isa_sa1,
  output logic        oe_isa_sa2,
  output logic        oe_isa_in,
  output logic        oe_isa_out,
  output logic        dir_isa_sd1,
  output logic        dir_isa_sd2,
  output logic        dir_isa_sa1,
  output logic        dir_isa_sa2,
  output logic        dir_isa_in,
  output logic        dir_isa_out,
  output logic [15:0] isa_sa,
  output logic        isa_iow,
  output logic        isa_ior,
  output logic        isa_rst_drv,
  output logic        isa_aen,
  output logic [15:0] isa_sd_out,
  output logic        isa_tri_en,
  input  logic [15:0] isa_sd_in,
  input  logic        iocs16,
  input  logic        irq5,
  input  logic        master_rst_drv,
  input  logic [3:0]  master_isa_state,
  input  logic [15:0] master_isa_sa_in,
  input  logic [15:0] master_isa_sd_in,
  output logic [15:0] slave_isa_rd_data,
  input  logic        ap_start,
  output logic        ap_idle,
  output logic        ap_done
);
  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt, lim;
  logic [3:0]  op_q, op_nxt;
  logic        accept, last;
  logic [1:0]  irq5_sync_unused;
  xcvr_t       oe_q, dir_q, oe_d, dir_d;

  always_comb begin
    accept = state == S_IDLE && ap_start && !master_rst_drv &&
             (master_isa_state == OP_WRITE || master_isa_state == OP_READ);
    op_nxt = accept ? master_isa_state : op_q;
    lim = state == S_SETUP  ? 8'(SETUP_CYC)  :
          state == S_STROBE ? 8'(STROBE_CYC) :
          state == S_HOLD   ? 8'(HOLD_CYC)   : 8'(TIMEOUT_CYC);
    last = cnt == lim - 8'd1;
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = accept ? S_SETUP : S_IDLE;
      S_SETUP:   state_nxt = last ? S_WAIT_CS : S_SETUP;
      S_WAIT_CS: state_nxt = !iocs16 ? S_STROBE : last ? S_ABORT : S_WAIT_CS;
      S_STROBE:  state_nxt = last ? S_HOLD : S_STROBE;
      S_HOLD:    state_nxt = last ? S_DONE : S_HOLD;
      S_ABORT:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    cnt_nxt = state_nxt != state ? 8'd0 : cnt + 8'd1;
  end

  // decoded against the next state so the buffers switch on the same edge as AEN
  isa_xcvr_ctrl u_xcvr (.state(state_nxt), .op(op_nxt), .oe(oe_d), .dir(dir_d));

  always_ff @(posedge clk_in_16m or negedge rst_n)
    if (!rst_n) begin
      state             <= S_IDLE;
      cnt               <= '0;
      op_q              <= OP_IDLE;
      isa_sa            <= '0;
      isa_iow           <= 1'b1;
      isa_ior           <= 1'b1;
      isa_aen           <= 1'b1;
      isa_tri_en        <= 1'b0;
      isa_sd_out        <= '0;
      slave_isa_rd_data <= '0;
      ap_idle           <= 1'b1;
      ap_done           <= 1'b0;
      isa_rst_drv       <= 1'b1;
      oe_q              <= '1;
      dir_q             <= 6'b001101;
      irq5_sync_unused  <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      op_q        <= op_nxt;
      isa_sa      <= accept ? master_isa_sa_in : bus_active(state_nxt) ? isa_sa : 16'h0000;
      isa_aen     <= !bus_active(state_nxt);
      isa_tri_en  <= bus_active(state_nxt) && op_nxt == OP_WRITE;
      if (accept && master_isa_state == OP_WRITE) isa_sd_out <= master_isa_sd_in;
      isa_iow     <= !(state_nxt == S_STROBE && op_nxt == OP_WRITE);
      isa_ior     <= !(state_nxt == S_STROBE && op_nxt == OP_READ);
      if (state == S_STROBE && state_nxt == S_HOLD && op_q == OP_READ) slave_isa_rd_data <= isa_sd_in;
      else if (state_nxt == S_ABORT && op_q == OP_READ) slave_isa_rd_data <= 16'hFFFF;
      ap_idle     <= state_nxt == S_IDLE;
      ap_done     <= state_nxt == S_DONE;
      isa_rst_drv <= master_rst_drv;
      oe_q        <= oe_d;
      dir_q       <= dir_d;
      irq5_sync_unused <= {irq5_sync_unused[0], irq5};
    end

  assign {oe_isa_sd1, oe_isa_sd2, oe_isa_sa1, oe_isa_sa2, oe_isa_in, oe_isa_out} = oe_q;
  assign {dir_isa_sd1, dir_isa_sd2, dir_isa_sa1, dir_isa_sa2, dir_isa_in, dir_isa_out} = dir_q;
endmodule

// File: tb/tb_isa_bus_controller.sv
// tb_isa_bus_controller: directed ISA write/read/timeout/reset vectors with a one-register bus target at EAC8
`timescale 1ns/1ps
module tb_isa_bus_controller;
  logic clk_in_16m = 1'b0, rst_n = 1'b1;
  logic oe_isa_sd1, oe_isa_sd2, oe_isa_sa1, oe_isa_sa2, oe_isa_in, oe_isa_out;
  logic dir_isa_sd1, dir_isa_sd2, dir_isa_sa1, dir_isa_sa2, dir_isa_in, dir_isa_out;
  logic [15:0] isa_sa, isa_sd_out, isa_sd_in, slave_isa_rd_data;
  logic isa_iow, isa_ior, isa_rst_drv, isa_aen, isa_tri_en, iocs16, ap_idle, ap_done;
  logic irq5 = 1'b0, master_rst_drv = 1'b0, ap_start = 1'b0;
  logic [3:0]  master_isa_state = 4'd0;
  logic [15:0] master_isa_sa_in = '0, master_isa_sd_in = '0, bus_mem = '0;

  isa_bus_controller dut (
    .clk_in_16m(clk_in_16m), .rst_n(rst_n),
    .oe_isa_sd1(oe_isa_sd1), .oe_isa_sd2(oe_isa_sd2), .oe_isa_sa1(oe_isa_sa1),
    .oe_isa_sa2(oe_isa_sa2), .oe_isa_in(oe_isa_in), .oe_isa_out(oe_isa_out),
    .dir_isa_sd1(dir_isa_sd1), .dir_isa_sd2(dir_isa_sd2), .dir_isa_sa1(dir_isa_sa1),
    .dir_isa_sa2(dir_isa_sa2), .dir_isa_in(dir_isa_in), .dir_isa_out(dir_isa_out),
    .isa_sa(isa_sa), .isa_iow(isa_iow), .isa_ior(isa_ior), .isa_rst_drv(isa_rst_drv),
    .isa_aen(isa_aen), .isa_sd_out(isa_sd_out), .isa_tri_en(isa_tri_en), .isa_sd_in(isa_sd_in),
    .iocs16(iocs16), .irq5(irq5), .master_rst_drv(master_rst_drv),
    .master_isa_state(master_isa_state), .master_isa_sa_in(master_isa_sa_in),
    .master_isa_sd_in(master_isa_sd_in), .slave_isa_rd_data(slave_isa_rd_data),
    .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done)
  );

  always #31 clk_in_16m = ~clk_in_16m;

  assign iocs16 = !(!isa_aen && isa_sa == 16'hEAC8);
  assign isa_sd_in = bus_mem;
  always @(posedge clk_in_16m) if (!isa_iow && isa_tri_en && isa_sa == 16'hEAC8) bus_mem <= isa_sd_out;

  int n_vec = 0, n_err = 0;
  int done_cnt, done_at, wr_lo, rd_lo, tri_lo, dir_lo, oe_lo, aen_lo, busy_idle;
  logic idle_after;
  logic [15:0] sd_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] sa, input logic [15:0] sd);
    @(negedge clk_in_16m);
    master_isa_state = op; master_isa_sa_in = sa; master_isa_sd_in = sd; ap_start = 1'b1;
    @(negedge clk_in_16m);
    ap_start = 1'b0;
  endtask

  // sample i is taken after the (i+1)th edge following the accepting edge
  task automatic watch(input int budget, input bit poke);
    done_cnt = 0; done_at = -1; wr_lo = 0; rd_lo = 0; tri_lo = 0; dir_lo = 0;
    oe_lo = 0; aen_lo = 0; busy_idle = 0; idle_after = 1'b0; sd_at = '0;
    for (int i = 0; i < budget; i++) begin
      if (poke && i == 4) begin ap_start = 1'b1; master_isa_state = 4'd2; end
      if (poke && i == 5) ap_start = 1'b0;
      @(negedge clk_in_16m);
      if (ap_done) begin done_cnt++; if (done_at < 0) done_at = i; end
      if (done_at >= 0 && i == done_at + 1) idle_after = ap_idle;
      if (!isa_aen) aen_lo++;
      if (!isa_aen && ap_idle) busy_idle++;
      if (!isa_iow) begin wr_lo++; sd_at = isa_sd_out; end
      if (!isa_ior) rd_lo++;
      if (!isa_iow || !isa_ior) begin
        if (isa_tri_en) tri_lo++;
        if (dir_isa_sd1 && dir_isa_sd2) dir_lo++;
        if (!oe_isa_sd1 && !oe_isa_sd2) oe_lo++;
      end
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #3;
    check("rst_iow", isa_iow, 1);
    check("rst_ior", isa_ior, 1);
    check("rst_aen", isa_aen, 1);
    check("rst_sa", isa_sa, 0);
    check("rst_tri", isa_tri_en, 0);
    check("rst_sd_out", isa_sd_out, 0);
    check("rst_rd", slave_isa_rd_data, 0);
    check("rst_idle_done", {ap_idle, ap_done}, 2'b10);
    check("rst_drv", isa_rst_drv, 1);
    check("rst_oe", {oe_isa_sd1, oe_isa_sd2, oe_isa_sa1, oe_isa_sa2, oe_isa_in, oe_isa_out}, 6'b111111);
    check("rst_dir", {dir_isa_sd1, dir_isa_sd2, dir_isa_sa1, dir_isa_sa2, dir_isa_in, dir_isa_out}, 6'b001101);
    @(negedge clk_in_16m) rst_n = 1'b1;
    repeat (2) @(negedge clk_in_16m);
    check("idle_oe", {oe_isa_sd1, oe_isa_sd2, oe_isa_sa1, oe_isa_sa2, oe_isa_in, oe_isa_out}, 6'b110000);
    check("idle_rst_drv", isa_rst_drv, 0);

    issue(4'd1, 16'hEAC8, 16'hABCD);
    watch(45, 1'b0);
    check("wr_done_cnt", done_cnt, 1);
    check("wr_done_at", done_at, 10);
    check("wr_iow_lo", wr_lo, 6);
    check("wr_ior_lo", rd_lo, 0);
    check("wr_sd_out", sd_at, 16'hABCD);
    check("wr_tri_en", tri_lo, 6);
    check("wr_dir_sd", dir_lo, 6);
    check("wr_oe_sd", oe_lo, 6);
    check("wr_busy_idle", busy_idle, 0);
    check("wr_idle_after", idle_after, 1);

    issue(4'd2, 16'hEAC8, 16'h0000);
    watch(45, 1'b0);
    check("rd_done_cnt", done_cnt, 1);
    check("rd_done_at", done_at, 10);
    check("rd_ior_lo", rd_lo, 6);
    check("rd_iow_lo", wr_lo, 0);
    check("rd_tri_en", tri_lo, 0);
    check("rd_dir_sd", dir_lo, 0);
    check("rd_data", slave_isa_rd_data, 16'hABCD);

    issue(4'd2, 16'h1234, 16'h0000);
    watch(45, 1'b0);
    check("to_done_cnt", done_cnt, 1);
    check("to_done_at", done_at, 34);
    check("to_strobes", rd_lo + wr_lo, 0);
    check("to_rd_data", slave_isa_rd_data, 16'hFFFF);

    issue(4'd1, 16'hEAC8, 16'h1357);
    watch(45, 1'b1);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_ior_lo", rd_lo, 0);
    check("busy_start_iow_lo", wr_lo, 6);
    check("wr_keeps_rd_data", slave_isa_rd_data, 16'hFFFF);

    issue(4'd0, 16'hEAC8, 16'h0000);
    watch(20, 1'b0);
    check("op0_done_cnt", done_cnt, 0);
    check("op0_aen_lo", aen_lo, 0);

    issue(4'd2, 16'hEAC8, 16'h0000);
    watch(45, 1'b0);
    check("rd2_data", slave_isa_rd_data, 16'h1357);

    issue(4'd1, 16'hEAC8, 16'hBEEF);
    repeat (4) @(negedge clk_in_16m);
    check("mid_iow_pre", isa_iow, 0);
    #5 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {isa_iow, isa_ior}, 2'b11);
    check("mid_rst_aen", isa_aen, 1);
    check("mid_rst_oe_sd", {oe_isa_sd1, oe_isa_sd2}, 2'b11);
    check("mid_rst_idle_done", {ap_idle, ap_done}, 2'b10);
    @(negedge clk_in_16m) rst_n = 1'b1;
    watch(20, 1'b0);
    check("mid_rst_no_done", done_cnt, 0);

    @(negedge clk_in_16m) master_rst_drv = 1'b1;
    @(negedge clk_in_16m);
    check("mrd_rst_drv", isa_rst_drv, 1);
    issue(4'd1, 16'hEAC8, 16'h2468);
    watch(20, 1'b0);
    check("mrd_done_cnt", done_cnt, 0);
    check("mrd_aen_lo", aen_lo, 0);
    master_rst_drv = 1'b0;
    @(negedge clk_in_16m);
    check("mrd_release", isa_rst_drv, 0);
    issue(4'd1, 16'hEAC8, 16'h2468);
    watch(45, 1'b0);
    check("mrd_wr_done_cnt", done_cnt, 1);
    check("mrd_wr_iow_lo", wr_lo, 6);
    check("mrd_wr_sd_out", sd_at, 16'h2468);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
